alu_fu_mc: RTL and testbench

- Parametrised, registered, multi-cycle successor to the combinational ALU functional unit in the EXE stage.
- Adds generic operand width (XLEN), a valid/ready handshake on input and output, a passthrough tag, and a flush.
- Shifts use an area-saving iterative shifter that moves SHIFT_STEP bits per cycle; all other ops complete in one registered cycle.
- Sits between the EXE issue logic and the EXE result mux/writeback path.

---
 rtl/cpu_structs_pkg.sv | 35 +++
 rtl/alu_operand_mux.sv | 27 ++
 rtl/alu_fu_mc.sv | 154 +++++++++++++++
 tb/tb_alu_fu_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_structs_pkg.sv
// Shared EXE-stage types: operand selects, ALU ops and multi-cycle ALU FSM states.
package cpu_structs_pkg;

  typedef enum logic [2:0] {
    AM_RS1 = 3'd0,
    AM_RS2 = 3'd1,
    AM_IMM = 3'd2,
    AM_PC  = 3'd3
  } ALU_SEL_TYPE;

  typedef enum logic [3:0] {
    A_AND  = 4'd0,
    A_OR   = 4'd1,
    A_XOR  = 4'd2,
    A_ADD  = 4'd3,
    A_SUB  = 4'd4,
    A_SLL  = 4'd5,
    A_SRL  = 4'd6,
    A_SRA  = 4'd7,
    A_SLT  = 4'd8,
    A_SLTU = 4'd9
  } ALU_OP_TYPE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ALU_MC_STATE_TYPE;

  // Shift ops take the iterative path, everything else completes in one cycle.
  function automatic logic is_shift(input ALU_OP_TYPE op);
    return (op == A_SLL) || (op == A_SRL) || (op == A_SRA);
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Combinational ALU operand selector; unknown select codes yield zero.
module alu_operand_mux
  import cpu_structs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  ALU_SEL_TYPE     sel,
  output logic [XLEN-1:0] data_c
);

  // Select one of the four operand sources.
  always_comb begin
    data_c = '0;
    case (sel)
      AM_RS1:  data_c = rs1_data;
      AM_RS2:  data_c = rs2_data;
      AM_IMM:  data_c = imm;
      AM_PC:   data_c = pc;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_fu_mc.sv
// Registered multi-cycle ALU functional unit with iterative shifter,
// valid/ready handshakes, passthrough tag and flush.
module alu_fu_mc
  import cpu_structs_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 4,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  ALU_SEL_TYPE      sel_x,
  input  ALU_SEL_TYPE      sel_y,
  input  ALU_OP_TYPE       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rd_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN still fits in the step compare.
  localparam int unsigned CW  = SHW + 1;

  ALU_MC_STATE_TYPE state;
  ALU_OP_TYPE       sh_op;
  logic [XLEN-1:0]  work;
  logic [CW-1:0]    remain;
  logic [XLEN-1:0]  mux_x;
  logic [XLEN-1:0]  mux_y;
  logic [XLEN-1:0]  alu_res;
  logic [CW-1:0]    step;
  logic [CW-1:0]    remain_nxt;
  logic [XLEN-1:0]  work_nxt;
  logic [CW-1:0]    shamt;
  logic             accept;

  alu_operand_mux #(.XLEN(XLEN)) u_mux_x (
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .sel      (sel_x),
    .data_c   (mux_x)
  );

  alu_operand_mux #(.XLEN(XLEN)) u_mux_y (
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .sel      (sel_y),
    .data_c   (mux_y)
  );

  // Ready when idle or when the held result drains this cycle; flush and reset block intake.
  always_comb begin
    in_ready = !reset_in && !flush_in &&
               ((state == IDLE) || ((state == DONE) && out_ready));
    accept   = in_valid && in_ready;
    shamt    = CW'(mux_y[SHW-1:0]);
  end

  // Single-cycle ALU result; shift ops are produced by the iterative path.
  always_comb begin
    alu_res = '0;
    case (op)
      A_AND:   alu_res = mux_x & mux_y;
      A_OR:    alu_res = mux_x | mux_y;
      A_XOR:   alu_res = mux_x ^ mux_y;
      A_ADD:   alu_res = mux_x + mux_y;
      A_SUB:   alu_res = mux_x - mux_y;
      A_SLT:   alu_res = XLEN'($signed(mux_x) < $signed(mux_y));
      A_SLTU:  alu_res = XLEN'(mux_x < mux_y);
      default: alu_res = '0;
    endcase
  end

  // One shifter step of min(SHIFT_STEP, remain); SRA keeps replicating the MSB.
  always_comb begin
    step       = (remain > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : remain;
    remain_nxt = remain - step;
    work_nxt   = work >> step;
    case (sh_op)
      A_SLL:   work_nxt = work << step;
      A_SRA:   work_nxt = XLEN'($signed(work) >>> step);
      default: work_nxt = work >> step;
    endcase
  end

  // Control FSM and registered result/tag; flush outranks drain and accept.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rd_data   <= '0;
      out_tag   <= '0;
      remain    <= '0;
      work      <= '0;
      sh_op     <= A_AND;
    end else if (flush_in) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      remain    <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
      if (is_shift(op)) begin
        work   <= mux_x;
        sh_op  <= op;
        remain <= shamt;
        if (shamt == '0) begin
          rd_data   <= mux_x;
          out_valid <= 1'b1;
          state     <= DONE;
        end else begin
          out_valid <= 1'b0;
          state     <= SHIFT;
        end
      end else begin
        rd_data   <= alu_res;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end else begin
      case (state)
        SHIFT: begin
          work   <= work_nxt;
          remain <= remain_nxt;
          if (remain_nxt == '0) begin
            rd_data   <= work_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fu_mc.sv
// Scoreboard bench for alu_fu_mc (XLEN=32, SHIFT_STEP=4).
module tb_alu_fu_mc;
  import cpu_structs_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic        clk;
  logic        reset_in;
  logic        flush_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  ALU_SEL_TYPE sel_x, sel_y;
  ALU_OP_TYPE  op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic [4:0]  out_tag;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu_fu_mc #(.XLEN(32), .SHIFT_STEP(4), .TAG_W(5)) dut (
    .clk_in    (clk),
    .reset_in  (reset_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .pc        (pc),
    .sel_x     (sel_x),
    .sel_y     (sel_y),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_data   (rd_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel_val(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] i,
                                          input logic [31:0] p);
    case (s)
      3'd0:    return a;
      3'd1:    return b;
      3'd2:    return i;
      3'd3:    return p;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [31:0] sx;
    logic [4:0] sh;
    sx = $signed(x);
    sh = y[4:0];
    case (o)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x ^ y;
      4'd3:    return x + y;
      4'd4:    return x - y;
      4'd5:    return x << sh;
      4'd6:    return x >> sh;
      4'd7:    return 32'(sx >>> sh);
      4'd8:    return {31'd0, ($signed(x) < $signed(y))};
      4'd9:    return {31'd0, (x < y)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [3:0] o, input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    if ((o == 4'd5 || o == 4'd6 || o == 4'd7) && sh != 0) return 1 + (sh + 3) / 4;
    return 1;
  endfunction

  // Put a request on the input bus (caller is at posedge+2).
  task automatic set_req(input logic [3:0] o, input logic [2:0] sxv, input logic [2:0] syv,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] p, input logic [4:0] t);
    op       = ALU_OP_TYPE'(o);
    sel_x    = ALU_SEL_TYPE'(sxv);
    sel_y    = ALU_SEL_TYPE'(syv);
    rs1_data = a;
    rs2_data = b;
    imm      = i;
    pc       = p;
    in_tag   = t;
    in_valid = 1'b1;
  endtask

  function automatic exp_t expect_of(input logic [3:0] o, input logic [2:0] sxv,
                                     input logic [2:0] syv, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] i,
                                     input logic [31:0] p, input logic [4:0] t);
    exp_t e;
    e.data = model(o, sel_val(sxv, a, b, i, p), sel_val(syv, a, b, i, p));
    e.tag  = t;
    return e;
  endfunction

  // Drive one request until accepted; returns at posedge+2 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [2:0] sxv, input logic [2:0] syv,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] p, input logic [4:0] t, input bit push);
    bit got;
    got = 1'b0;
    set_req(o, sxv, syv, a, b, i, p, t);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("accept_timeout", 64'(got), 64'd1);
    if (got && push) sb.push_back(expect_of(o, sxv, syv, a, b, i, p, t));
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Count accept-edge-inclusive cycles until out_valid shows up.
  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check(name, 64'(lat), 64'(exp_lat));
    @(posedge clk); #2;
  endtask

  // Scoreboard: compare each handshaked result; nothing may be valid with an empty queue.
  always @(negedge clk) begin
    if (!reset_in) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'd0);
      end else if (out_valid && out_ready) begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", 64'(rd_data), 64'(e.data));
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ops_tbl [11];
    logic [3:0]  ro;
    logic [2:0]  rsx, rsy;
    logic [31:0] ra, rb, ri, rp;
    exp_t        e;
    ops_tbl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};

    reset_in  = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rs1_data  = '0; rs2_data = '0; imm = '0; pc = '0;
    sel_x     = AM_RS1; sel_y = AM_RS2; op = A_ADD; in_tag = '0;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_in = 1'b0;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ADD wraps
    issue(4'd3, 3'd0, 3'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd1, 1'b1);
    wait_result("add_lat", 1);

    // SLT then SLTU back-to-back
    set_req(4'd8, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd2);
    @(negedge clk);
    check("b2b_ready0", 64'(in_ready), 64'd1);
    sb.push_back(expect_of(4'd8, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd2));
    @(posedge clk); #2;
    set_req(4'd9, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
    @(negedge clk);
    check("b2b_ready1", 64'(in_ready), 64'd1);
    check("b2b_valid0", 64'(out_valid), 64'd1);
    sb.push_back(expect_of(4'd9, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3));
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid1", 64'(out_valid), 64'd1);
    @(posedge clk); #2;

    // Iterative shifts
    issue(4'd5, 3'd0, 3'd1, 32'd1, 32'd13, 32'd0, 32'd0, 5'd4, 1'b1);
    check("sll_busy_ready", 64'(in_ready), 64'd0);
    wait_result("sll_lat", 5);
    issue(4'd7, 3'd0, 3'd1, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 5'd5, 1'b1);
    wait_result("sra_lat", 9);
    issue(4'd6, 3'd0, 3'd2, 32'hDEAD_BEEF, 32'd0, 32'd32, 32'd0, 5'd6, 1'b1);
    wait_result("srl_zero_lat", 1);

    // Random mix including PC source, an invalid select and an unlisted op
    for (int r = 0; r < 12; r++) begin
      ro  = ops_tbl[$urandom_range(0, 10)];
      rsx = 3'($urandom_range(0, 4));
      rsy = 3'($urandom_range(0, 4));
      if (rsx == 3'd4) rsx = 3'd5;
      if (rsy == 3'd4) rsy = 3'd5;
      ra = $urandom; rb = $urandom; ri = $urandom; rp = $urandom;
      issue(ro, rsx, rsy, ra, rb, ri, rp, 5'(r + 10), 1'b1);
      wait_result("rand_lat", exp_latency(ro, sel_val(rsy, ra, rb, ri, rp)));
    end

    // Backpressure: result held, then drain and accept in the same cycle
    out_ready = 1'b0;
    issue(4'd1, 3'd0, 3'd1, 32'h0000_00F0, 32'h0000_0F00, 32'd0, 32'd0, 5'd7, 1'b1);
    set_req(4'd2, 3'd0, 3'd1, 32'h0000_1234, 32'h0000_00FF, 32'd0, 32'd0, 5'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_rd_data", 64'(rd_data), 64'h0FF0);
      check("bp_out_tag", 64'(out_tag), 64'd7);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_accept", 64'(in_ready), 64'd1);
    e = expect_of(4'd2, 3'd0, 3'd1, 32'h0000_1234, 32'h0000_00FF, 32'd0, 32'd0, 5'd9);
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #2;

    // Flush two cycles into a long SRL; nothing may come out
    issue(4'd6, 3'd0, 3'd1, 32'hFFFF_0000, 32'd20, 32'd0, 32'd0, 5'd11, 1'b0);
    @(posedge clk); #2;
    flush_in = 1'b1;
    set_req(4'd3, 3'd0, 3'd1, 32'd7, 32'd8, 32'd0, 32'd0, 5'd12);
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #2;
    flush_in = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    #2;

    // Asynchronous reset in the middle of a shift
    issue(4'd5, 3'd0, 3'd1, 32'h0000_0003, 32'd30, 32'd0, 32'd0, 5'd13, 1'b0);
    @(posedge clk); #3;
    reset_in = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    check("mid_rst_out_tag", 64'(out_tag), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_in = 1'b0;
    issue(4'd3, 3'd0, 3'd1, 32'd2, 32'd3, 32'd0, 32'd0, 5'd14, 1'b1);
    wait_result("add_after_rst_lat", 1);

    // Wait for the scoreboard to empty
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #2;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
